// File: rtl/channel_mux_pkg.sv
// Shared constants for the channel_mux_rr block: mode encodings and default sizing.
package channel_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Index width for a channel count; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid channel at or above ptr, wrapping.
module rr_picker
  import channel_mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                found
);

  int idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (!found && valid[idx]) begin
        found = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/channel_mux_rr.sv
// N:1 channel mux with fixed/round-robin grant into a single output register.
// Define CHANNEL_MUX_XFER_COUNT_EN to add a 16-bit output handshake counter (xfer_count).
module channel_mux_rr
  import channel_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W   = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef CHANNEL_MUX_XFER_COUNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  assign ch_data = in_data;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] chan_q,  chan_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic             fix_found;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_ok;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  rr_picker #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_picker (
    .valid (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .found (rr_found)
  );

  // sel values past the last channel simply match nothing.
  always_comb begin
    fix_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) fix_found = in_valid[i];
    end
  end

  always_comb begin
    grant_idx  = (mode == MODE_RR) ? rr_grant : sel;
    grant_ok   = (mode == MODE_RR) ? rr_found : fix_found;
    can_accept = (state_q == ST_EMPTY) || out_ready;
    xfer       = grant_ok && can_accept && !reset;
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        grant_data  = ch_data[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      data_d = grant_data;
      chan_d = grant_idx;
      if (mode == MODE_RR)
        ptr_d = (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = (state_q == ST_FULL);

`ifdef CHANNEL_MUX_XFER_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign xfer_count = count_q;
`endif

endmodule

// File: tb/tb_channel_mux_rr.sv
// Directed bench for channel_mux_rr (WIDTH=8, CHANNELS=8) with hand-computed expectations.
module tb_channel_mux_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef CHANNEL_MUX_XFER_COUNT_EN
  logic [15:0] xfer_count;
`endif

  int checks = 0;
  int fails  = 0;

  channel_mux_rr #(.WIDTH(8), .CHANNELS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CHANNEL_MUX_XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [7:0] v);
    in_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_ch(i, 8'(i + 8'h30));
    #1;
    checks++; if (in_ready !== 8'h00) begin fails++; $display("FAIL reset_in_ready: got %h expected 00", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", out_data); end
    checks++; if (out_chan !== 3'd0) begin fails++; $display("FAIL reset_chan: got %0d expected 0", out_chan); end
    reset = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; set_ch(3, 8'h0E); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h08) begin fails++; $display("FAIL fixed_in_ready: got %h expected 08", in_ready); end
    tick();
    checks++; if (out_data !== 8'h0E) begin fails++; $display("FAIL fixed_data: got %h expected 0e", out_data); end
    checks++; if (out_chan !== 3'd3) begin fails++; $display("FAIL fixed_chan: got %0d expected 3", out_chan); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fixed_valid: got %b expected 1", out_valid); end
    in_valid = 8'h00;
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fixed_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_fixed_idle();
    mode = 1'b0; sel = 3'd1; in_valid = 8'h01; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h00) begin fails++; $display("FAIL idle_in_ready: got %h expected 00", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    set_ch(0, 8'hA0); set_ch(2, 8'hA2); set_ch(5, 8'hA5);
    mode = 1'b1; in_valid = 8'h20; out_ready = 1'b1;
    tick();
    checks++; if (out_chan !== 3'd5 || out_data !== 8'hA5) begin fails++; $display("FAIL wrap_ch5: got chan %0d data %h expected 5 a5", out_chan, out_data); end
    in_valid = 8'h05;
    #1;
    checks++; if (in_ready !== 8'h01) begin fails++; $display("FAIL wrap_grant0: got %h expected 01", in_ready); end
    tick();
    checks++; if (out_chan !== 3'd0 || out_data !== 8'hA0) begin fails++; $display("FAIL wrap_ch0: got chan %0d data %h expected 0 a0", out_chan, out_data); end
    checks++; if (in_ready !== 8'h04) begin fails++; $display("FAIL wrap_grant2: got %h expected 04", in_ready); end
    tick();
    checks++; if (out_chan !== 3'd2 || out_data !== 8'hA2) begin fails++; $display("FAIL wrap_ch2: got chan %0d data %h expected 2 a2", out_chan, out_data); end
  endtask

  task automatic test_rr_sweep();
    do_reset();
    for (int i = 0; i < 8; i++) set_ch(i, 8'(i + 4));
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_rdy;
      exp_rdy = 8'h01 << (k % 8);
      #1;
      checks++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL sweep_rdy[%0d]: got %h expected %h", k, in_ready, exp_rdy); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_chan !== 3'(k % 8) || out_data !== 8'((k % 8) + 4))
        begin fails++; $display("FAIL sweep_out[%0d]: got v%b chan %0d data %h expected v1 chan %0d data %h", k, out_valid, out_chan, out_data, k % 8, (k % 8) + 4); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    mode = 1'b0; sel = 3'd0; in_valid = 8'h01; set_ch(0, 8'h07); set_ch(2, 8'h55); out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 8'h07) begin fails++; $display("FAIL hold_load: got %h expected 07", out_data); end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = 3'(k + 1); mode = k[0]; in_valid = 8'hFF; set_ch(0, 8'(8'h60 + k));
      #1;
      checks++; if (in_ready !== 8'h00) begin fails++; $display("FAIL hold_rdy[%0d]: got %h expected 00", k, in_ready); end
      tick();
      checks++; if (out_data !== 8'h07 || out_chan !== 3'd0 || out_valid !== 1'b1)
        begin fails++; $display("FAIL hold_out[%0d]: got v%b chan %0d data %h expected v1 chan 0 data 07", k, out_valid, out_chan, out_data); end
    end
    mode = 1'b0; sel = 3'd2; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h04) begin fails++; $display("FAIL hold_release_rdy: got %h expected 04", in_ready); end
    tick();
    checks++; if (out_data !== 8'h55 || out_chan !== 3'd2) begin fails++; $display("FAIL hold_release: got chan %0d data %h expected 2 55", out_chan, out_data); end
  endtask

  task automatic test_reset_full();
    do_reset();
    mode = 1'b0; sel = 3'd3; in_valid = 8'h08; set_ch(3, 8'h3C); out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin fails++; $display("FAIL rstfull_load: got v%b data %h expected v1 3c", out_valid, out_data); end
    reset = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h00) begin fails++; $display("FAIL rstfull_rdy: got %h expected 00", in_ready); end
    tick();
    reset = 1'b0; in_valid = 8'h00;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 3'd0)
      begin fails++; $display("FAIL rstfull_out: got v%b chan %0d data %h expected v0 0 00", out_valid, out_chan, out_data); end
`ifdef CHANNEL_MUX_XFER_COUNT_EN
    checks++; if (xfer_count !== 16'd0) begin fails++; $display("FAIL count_init: got %0d expected 0", xfer_count); end
    sel = 3'd0; in_valid = 8'h01; out_ready = 1'b1;
    tick(); tick(); tick();
    in_valid = 8'h00;
    tick(); tick();
    checks++; if (xfer_count !== 16'd3) begin fails++; $display("FAIL count_three: got %0d expected 3", xfer_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (xfer_count !== 16'd0) begin fails++; $display("FAIL count_reset: got %0d expected 0", xfer_count); end
`endif
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    test_reset();
    test_fixed();
    test_fixed_idle();
    test_rr_wrap();
    test_rr_sweep();
    test_hold();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/channel_mux_rr.md
CHANNEL_MUX_RR -- requirements
Module: channel_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 8, input channel count (legal range 2..16).
REQ-003 SHALL derive localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_data  input  CHANNELS*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel data valid.
REQ-009 in_ready  output  CHANNELS  per-channel accept; a transfer occurs on channel i when in_valid[i] and in_ready[i] are both high.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 sel  input  SEL_W  channel index used in fixed mode.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_chan  output  SEL_W  index of channel that supplied out_data.
REQ-014 out_valid  output  1  out_data holds an untaken word.
REQ-015 out_ready  input  1  downstream accept.

Function
REQ-016 SHALL hold one output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 can_accept SHALL be high when EMPTY, or FULL with out_ready=1 (same-cycle replace, throughput 1 word/cycle).
REQ-018 At most one in_ready bit SHALL be high per cycle, and only when can_accept=1 and that channel is granted.
REQ-019 Fixed mode: grant = sel when in_valid[sel]=1; sel >= CHANNELS SHALL grant nothing.
REQ-020 Round-robin mode: grant = first channel with in_valid=1 searching from pointer upward, wrapping CHANNELS-1 -> 0.
REQ-021 On a round-robin transfer, pointer SHALL become grant+1, wrapping to 0 at CHANNELS; pointer SHALL not change in fixed mode or on cycles with no transfer.
REQ-022 Latency: word accepted at edge N SHALL appear on out_data/out_chan with out_valid=1 after edge N.
REQ-023 Transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on out_ready with accept (new word loaded) or on !out_ready (hold).
REQ-024 While FULL and out_ready=0, out_data and out_chan SHALL remain stable regardless of in_*, mode or sel changes.
REQ-025 mode or sel changes SHALL take effect for the grant in the same cycle; held data unaffected.

Reset
REQ-026 On reset: out_valid=0, out_data=0, out_chan=0, pointer=0, in_ready=0 during reset cycle.
REQ-027 Reset while FULL SHALL discard the held word; reset has priority over any transfer in that cycle.

Configuration
REQ-028 Macro CHANNEL_MUX_XFER_COUNT_EN defined: SHALL add output xfer_count (16-bit) counting out_valid&&out_ready cycles, reset to 0, wrapping 0xFFFF->0x0000.
REQ-029 Macro undefined: xfer_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package channel_mux_pkg SHALL hold MODE_FIXED=1'b0, MODE_RR=1'b1 and the default WIDTH/CHANNELS constants.
REQ-031 Sub-module rr_picker SHALL compute the combinational round-robin grant index and grant-found flag from in_valid and pointer.

Verification
REQ-032 Reset, then mode=0, sel=3, in_valid=8'h08, ch3=8'h0E, out_ready=1 -> next cycle out_data=8'h0E, out_chan=3, out_valid=1.
REQ-033 mode=0, sel=1, in_valid=8'h01 (ch1 idle) -> in_ready=0, out_valid stays 0.
REQ-034 mode=1, in_valid=8'hFF, ch i = i+4, out_ready=1 for 9 cycles -> out_chan sequence 0,1,...,7,0 with out_data 4..11,4.
REQ-035 FULL with out_data=8'h07, out_ready=0 for 3 cycles while inputs/sel change -> out_data stays 8'h07, in_ready=0; out_ready=1 -> pending word loads next cycle.
REQ-036 mode=1, pointer=6, in_valid=8'h05 -> grant ch0, pointer becomes 1; next grant ch2.
REQ-037 Reset asserted while FULL -> out_valid=0, out_data=0 next cycle; with CHANNEL_MUX_XFER_COUNT_EN, 3 transfers then reset -> xfer_count 3 then 0.
